// File: rtl/timeset_pkg.sv
// Shared types and constants for the time-set controller.
// State encoding, counter width and the default fast-set threshold live here.
package timeset_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SET_HOURS   = 2'd1,
        ST_SET_MINUTES = 2'd2
    } state_t;

    localparam int CNT_W              = 4;
    localparam int FAST_AFTER_DEFAULT = 4;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one button level (used only when TIMESET_SYNC_EN is defined).
// Flops reset to RESET_VAL so a button held through reset never looks like a fresh press.
module btn_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_btn,
    output logic o_btn
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_btn;
            sync_q <= meta_q;
        end
    end

    assign o_btn = sync_q;

endmodule

// File: rtl/timeset_ctrl.sv
// Clock time-set controller: button-driven hours/minutes increment with slow/fast auto-repeat.
// Define TIMESET_SYNC_EN to put a two-flop synchronizer (btn_sync) on each button input.
module timeset_ctrl
    import timeset_pkg::*;
#(
    parameter int FAST_AFTER = FAST_AFTER_DEFAULT
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_btn_hours,
    input  logic i_btn_minutes,
    input  logic i_timeset_stb,
    output logic o_divider_en,
    output logic o_fast_set,
    output logic o_inc_hours,
    output logic o_inc_minutes
);

    localparam logic [CNT_W-1:0] FAST_LIMIT = CNT_W'(FAST_AFTER);

    logic btn_hours_s;
    logic btn_minutes_s;

`ifdef TIMESET_SYNC_EN
    btn_sync #(.RESET_VAL(1'b1)) u_sync_hours (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_btn     (i_btn_hours),
        .o_btn     (btn_hours_s)
    );

    btn_sync #(.RESET_VAL(1'b1)) u_sync_minutes (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_btn     (i_btn_minutes),
        .o_btn     (btn_minutes_s)
    );
`else
    assign btn_hours_s   = i_btn_hours;
    assign btn_minutes_s = i_btn_minutes;
`endif

    logic             btn_hours_q;
    logic             btn_minutes_q;
    logic             rise_hours;
    logic             rise_minutes;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             inc_hours_q;
    logic             inc_hours_d;
    logic             inc_minutes_q;
    logic             inc_minutes_d;

    // Edge registers reset to "pressed" so a held button needs release and re-press.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            btn_hours_q   <= 1'b1;
            btn_minutes_q <= 1'b1;
        end else begin
            btn_hours_q   <= btn_hours_s;
            btn_minutes_q <= btn_minutes_s;
        end
    end

    assign rise_hours   = btn_hours_s & ~btn_hours_q;
    assign rise_minutes = btn_minutes_s & ~btn_minutes_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            inc_hours_q   <= 1'b0;
            inc_minutes_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            inc_hours_q   <= inc_hours_d;
            inc_minutes_q <= inc_minutes_d;
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        inc_hours_d   = 1'b0;
        inc_minutes_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Hours wins when both buttons rise together; strobes are ignored here.
                if (rise_hours) begin
                    state_d     = ST_SET_HOURS;
                    cnt_d       = '0;
                    inc_hours_d = 1'b1;
                end else if (rise_minutes) begin
                    state_d       = ST_SET_MINUTES;
                    cnt_d         = '0;
                    inc_minutes_d = 1'b1;
                end
            end

            ST_SET_HOURS: begin
                if (!btn_hours_s) begin
                    state_d = ST_IDLE;
                end else if (i_timeset_stb) begin
                    inc_hours_d = 1'b1;
                    if (cnt_q < FAST_LIMIT) cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SET_MINUTES: begin
                if (!btn_minutes_s) begin
                    state_d = ST_IDLE;
                end else if (i_timeset_stb) begin
                    inc_minutes_d = 1'b1;
                    if (cnt_q < FAST_LIMIT) cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign o_divider_en  = (state_q != ST_IDLE);
    assign o_fast_set    = (state_q != ST_IDLE) && (cnt_q == FAST_LIMIT);
    assign o_inc_hours   = inc_hours_q;
    assign o_inc_minutes = inc_minutes_q;

endmodule

// File: tb/tb_timeset_ctrl.sv
// Scoreboard bench for timeset_ctrl: press/hold/release sessions generate expected pulses and
// enable/fast windows from the behavioural rules; a negedge monitor compares every cycle.
module tb_timeset_ctrl;

    localparam int FA  = 4;
`ifdef TIMESET_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int INF = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic reset_n;
    logic btn_h;
    logic btn_m;
    logic stb;
    logic divider_en;
    logic fast_set;
    logic inc_hours;
    logic inc_minutes;

    always #10 clk = ~clk;

    timeset_ctrl #(.FAST_AFTER(FA)) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_btn_hours   (btn_h),
        .i_btn_minutes (btn_m),
        .i_timeset_stb (stb),
        .o_divider_en  (divider_en),
        .o_fast_set    (fast_set),
        .o_inc_hours   (inc_hours),
        .o_inc_minutes (inc_minutes)
    );

    typedef struct {
        int cyc;
        bit hours;
    } pulse_t;

    pulse_t exp_q[$];
    int     cyc      = 0;
    int     checks   = 0;
    int     failures = 0;
    int     win_e    = INF;
    int     win_x    = INF;
    int     win_fast = INF;
    bit     mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Monitor: set-state window gives enable/fast; pulse queue gives exact pulse cycles.
    always @(negedge clk) begin
        pulse_t p;
        if (mon_en) begin
            check("divider_en", divider_en, int'(cyc >= win_e && cyc < win_x));
            check("fast_set", fast_set, int'(cyc >= win_fast && cyc < win_x));
            check("inc_exclusive", int'(inc_hours & inc_minutes), 0);
            if (inc_hours || inc_minutes) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", int'({inc_hours, inc_minutes}), 0);
                end else begin
                    p = exp_q.pop_front();
                    check("pulse_cycle", cyc, p.cyc);
                    check("pulse_is_hours", int'(inc_hours), int'(p.hours));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                p = exp_q.pop_front();
                check("pulse_present", int'(inc_hours | inc_minutes), 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pulse(input int c, input bit h);
        pulse_t p;
        p.cyc   = c;
        p.hours = h;
        exp_q.push_back(p);
    endtask

    // Both buttons low; strobes optional after the previous session has fully exited.
    task automatic idle_gap(input int n, input bit with_stb);
        stb = 1'b0;
        repeat (LAT + 2) tick();
        repeat (n) begin
            tick();
            stb = with_stb ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        tick();
        stb = 1'b0;
    endtask

    // One press/hold/release of a button. Inputs set after tick() at cycle d are sampled by
    // the edge that starts cycle d+1; button effects appear LAT cycles later than strobes.
    task automatic session(input bit owner_hours, input bit both, input int n_stb,
                           input bit coincide, input bit toggle_other, input bit do_reset);
        int  e;
        int  d;
        int  k;
        int  r;
        bit  owner;
        owner = both ? 1'b1 : owner_hours;
        tick();
        e = cyc + 1 + LAT;
        if (owner || both) btn_h = 1'b1;
        if (!owner || both) btn_m = 1'b1;
        push_pulse(e, owner);
        win_e    = e;
        win_x    = INF;
        win_fast = INF;
        k        = 0;
        while (cyc < e) tick();
        for (int i = 0; i < n_stb; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            tick();
            d   = cyc;
            stb = 1'b1;
            if (toggle_other) begin
                if (owner) btn_m = 1'($urandom_range(0, 1));
                else       btn_h = 1'($urandom_range(0, 1));
            end
            k++;
            push_pulse(d + 1, owner);
            if (k == FA) win_fast = d + 1;
            tick();
            stb = 1'b0;
        end
        if (do_reset) begin
            tick();
            reset_n = 1'b0;
            win_x   = cyc + 1;
            tick();
            reset_n = 1'b1;
            // Button still held: strobes must be ignored and no new session may start.
            repeat (12) begin
                tick();
                stb = 1'($urandom_range(0, 1));
            end
            tick();
            stb = 1'b0;
            tick();
            btn_h = 1'b0;
            btn_m = 1'b0;
        end else begin
            tick();
            r     = cyc;
            btn_h = 1'b0;
            btn_m = 1'b0;
            win_x = r + 1 + LAT;
            if (coincide) begin
                repeat (LAT) tick();
                stb = 1'b1;
                tick();
                stb = 1'b0;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        btn_h   = 1'b0;
        btn_m   = 1'b0;
        stb     = 1'b0;
        repeat (2) tick();
        mon_en = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        idle_gap(4, 1'b0);

        // Hours tap, no strobes.
        session(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        idle_gap(5, 1'b0);
        // Minutes held for six strobes: seven pulses, fast after the fourth strobe.
        session(1'b0, 1'b0, 6, 1'b0, 1'b0, 1'b0);
        idle_gap(5, 1'b0);
        // Simultaneous press selects hours; minutes toggling is ignored.
        session(1'b1, 1'b1, 5, 1'b0, 1'b1, 1'b0);
        idle_gap(5, 1'b0);
        // Strobe coincident with hours release is dropped.
        session(1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        idle_gap(5, 1'b0);
        // Reset during fast minutes set, button held through it, then a fresh press.
        session(1'b0, 1'b0, FA + 1, 1'b0, 1'b0, 1'b1);
        idle_gap(5, 1'b0);
        session(1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        idle_gap(2, 1'b0);
        // Strobes in IDLE for 100 cycles.
        repeat (100) begin
            tick();
            stb = 1'($urandom_range(0, 1));
        end
        tick();
        stb = 1'b0;
        idle_gap(2, 1'b0);

        for (int s = 0; s < 25; s++) begin
            bit oh;
            bit bo;
            bit co;
            bit tg;
            oh = 1'($urandom_range(0, 1));
            bo = ($urandom_range(0, 3) == 0);
            co = 1'($urandom_range(0, 1));
            tg = 1'($urandom_range(0, 1));
            session(oh, bo, $urandom_range(0, 8), co, tg, 1'b0);
            idle_gap($urandom_range(0, 6), 1'b1);
        end

        repeat (8) tick();
        check("pulse_queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
